// File: rtl/phasediff_seq.sv
// Sequencer around a shared rec2pol: measures the angle of channel A, then channel B, and
// emits the wrapped A-B phase per measurement plus a block mean every 2^LOG2_NAVG results.
module phasediff_seq #(
   parameter int unsigned CORDIC_LAT = 18,
   parameter int unsigned LOG2_NAVG  = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               go,
   input  logic signed [12:0] xa,
   input  logic signed [12:0] ya,
   input  logic signed [12:0] xb,
   input  logic signed [12:0] yb,
   output logic               cordic_start,
   output logic signed [12:0] cordic_x,
   output logic signed [12:0] cordic_y,
   input  logic signed [18:0] cordic_angle,
   output logic               busy,
   output logic signed [18:0] diff_out,
   output logic               diff_valid,
   output logic signed [18:0] mean_out,
   output logic               mean_valid
);

   localparam int unsigned AW = 19 + LOG2_NAVG;
   localparam int unsigned CW = (CORDIC_LAT > 1) ? $clog2(CORDIC_LAT) : 1;
   localparam int unsigned NW = (LOG2_NAVG > 0) ? LOG2_NAVG : 1;
   localparam logic [CW-1:0] WAIT_LAST = CW'(CORDIC_LAT - 1);
   localparam logic [NW-1:0] MEAS_LAST = NW'((1 << LOG2_NAVG) - 1);
   localparam logic signed [19:0] HALF_TURN = 20'sd184320;
   localparam logic signed [19:0] FULL_TURN = 20'sd368640;

   typedef enum logic [2:0] {
      StIdle, StLoadA, StWaitA, StLoadB, StWaitB, StDiff, StDone
   } state_t;

   state_t                state;
   logic [CW-1:0]         wait_cnt;
   logic [NW-1:0]         meas_cnt;
   logic signed [12:0]    xb_q, yb_q;
   logic signed [18:0]    ang_a, ang_b;
   logic signed [AW-1:0]  acc;

   logic signed [19:0]    d_raw, d_wrap;
   logic signed [AW-1:0]  acc_sum;

   always_comb begin
      d_raw  = 20'(ang_a) - 20'(ang_b);
      d_wrap = d_raw;
      if (d_raw >= HALF_TURN) begin
         d_wrap = d_raw - FULL_TURN;
      end else if (d_raw < -HALF_TURN) begin
         d_wrap = d_raw + FULL_TURN;
      end
      acc_sum = acc + AW'(d_wrap);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= StIdle;
         wait_cnt     <= '0;
         meas_cnt     <= '0;
         xb_q         <= '0;
         yb_q         <= '0;
         ang_a        <= '0;
         ang_b        <= '0;
         acc          <= '0;
         cordic_start <= 1'b0;
         cordic_x     <= '0;
         cordic_y     <= '0;
         busy         <= 1'b0;
         diff_out     <= '0;
         diff_valid   <= 1'b0;
         mean_out     <= '0;
         mean_valid   <= 1'b0;
      end else begin
         cordic_start <= 1'b0;
         diff_valid   <= 1'b0;
         mean_valid   <= 1'b0;
         unique case (state)
            StIdle: begin
               if (go) begin
                  // Channel A operands go straight to rec2pol; B is held for the second pass.
                  cordic_x     <= xa;
                  cordic_y     <= ya;
                  xb_q         <= xb;
                  yb_q         <= yb;
                  cordic_start <= 1'b1;
                  busy         <= 1'b1;
                  state        <= StLoadA;
               end
            end
            StLoadA: begin
               wait_cnt <= '0;
               state    <= StWaitA;
            end
            StWaitA: begin
               if (wait_cnt == WAIT_LAST) begin
                  ang_a        <= cordic_angle;
                  cordic_x     <= xb_q;
                  cordic_y     <= yb_q;
                  cordic_start <= 1'b1;
                  state        <= StLoadB;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            StLoadB: begin
               wait_cnt <= '0;
               state    <= StWaitB;
            end
            StWaitB: begin
               if (wait_cnt == WAIT_LAST) begin
                  ang_b <= cordic_angle;
                  state <= StDiff;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            StDiff: begin
               diff_out   <= d_wrap[18:0];
               diff_valid <= 1'b1;
               busy       <= 1'b0;
               if (meas_cnt == MEAS_LAST) begin
                  mean_out   <= 19'(acc_sum >>> LOG2_NAVG);
                  mean_valid <= 1'b1;
                  acc        <= '0;
                  meas_cnt   <= '0;
               end else begin
                  acc      <= acc_sum;
                  meas_cnt <= meas_cnt + 1'b1;
               end
               state <= StDone;
            end
            StDone: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/phasediff_seq.md
Name: phasediff_seq

Overview:
- Sequencer and post-processor that sits directly downstream of rec2pol in the USBL bearing chain.
- Takes one quadrature sample (x,y) from each of two hydrophone channels, A and B.
- Time-multiplexes a single rec2pol instance: drives its x, y and start inputs, waits the fixed CORDIC latency, then captures the angle result.
- Outputs the wrapped A−B phase difference per measurement, plus a block mean over 2^LOG2_NAVG measurements.

Parameters:
- CORDIC_LAT, 18: cycles from the rec2pol start cycle to a valid rec2pol angle output.
- LOG2_NAVG, 2: log2 of the number of measurements averaged per mean_out.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- go  in  1  measurement request; sampled only in IDLE.
- xa  in  13  channel A in-phase, signed.
- ya  in  13  channel A quadrature, signed.
- xb  in  13  channel B in-phase, signed.
- yb  in  13  channel B quadrature, signed.
- cordic_start  out  1  one-cycle start pulse to rec2pol.
- cordic_x  out  13  x operand to rec2pol.
- cordic_y  out  13  y operand to rec2pol.
- cordic_angle  in  19  rec2pol angle, signed, degrees Q8.10.
- busy  out  1  high from go acceptance until the result is issued.
- diff_out  out  19  wrapped A−B phase, signed Q8.10 degrees.
- diff_valid  out  1  one-cycle strobe for diff_out.
- mean_out  out  19  mean of the last 2^LOG2_NAVG diff_out values, signed Q8.10.
- mean_valid  out  1  one-cycle strobe for mean_out.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, accumulator 0, measurement counter 0.
- Reset asserted mid-operation aborts the measurement and discards the partial accumulation. No strobe is issued for the aborted measurement.

State machine:
- IDLE → LOAD_A when go=1. Latch xa, ya, xb, yb; busy=1 from the next cycle.
- LOAD_A (1 cycle) → WAIT_A. In LOAD_A, cordic_start=1 and cordic_x/cordic_y = latched xa/ya.
- WAIT_A → LOAD_B after CORDIC_LAT−1 cycles. cordic_angle is registered as ang_a on the edge ending cycle s+CORDIC_LAT, where s is the LOAD_A cycle.
- LOAD_B / WAIT_B: identical to LOAD_A / WAIT_A, using the latched xb/yb; captures ang_b.
- DIFF (1 cycle): computes the wrapped difference and updates the accumulator; → DONE.
- DONE (1 cycle): diff_valid=1 (and mean_valid=1 if the block completes), busy=0 → IDLE.

Handshake and timing:
- cordic_x/cordic_y hold the channel operands throughout each LOAD+WAIT phase. They hold their last value in IDLE.
- go is ignored while busy=1, including in the DONE cycle; no queuing.
- go sampled high in cycle g gives diff_valid in cycle g+2·CORDIC_LAT+4 (g+40 at default). The next go is accepted one cycle after DONE.
- Inputs xa, ya, xb, yb may change freely after the go cycle.

Arithmetic:
- d = ang_a − ang_b, computed at 20 bits signed.
- If d ≥ 184320 (180°): d −= 368640. Else if d < −184320: d += 368640.
- Result lies in [−180°, 180°) and is truncated to 19 bits for diff_out.
- The accumulator is 19+LOG2_NAVG bits signed and adds the wrapped d each measurement.
- When the counter reaches 2^LOG2_NAVG−1:
  - mean_out = accumulator >>> LOG2_NAVG (arithmetic shift, floor), using the sum that includes this measurement.
  - Accumulator and counter clear.
- Otherwise the counter increments.
- mean_out and diff_out hold between strobes.
- No circular averaging: sets straddling ±180° give a biased mean. This is a known and accepted limitation.

Test Plan:
- Reset, then hold go=0 for 50 cycles → all outputs stay 0, cordic_start never pulses, busy=0.
- A=(4095,4095), B=(−4095,4095), go pulse in cycle g → cordic_start high in cycles g+1 and g+20; diff_valid in cycle g+40; diff_out ≈ −92160 (−90°) within ±51 LSB.
- A=(−4095,−4095), B=(−4095,4095) → raw −270° wraps; diff_out ≈ +92160 (+90°). Swap A and B → ≈ −92160. A=(0,4095), B=(0,−4095) → raw +180° wraps to −184320 ±51.
- LOG2_NAVG=2 with four measurements alternating +90° and −90° → mean_valid only on the 4th diff_valid, mean_out ≈ 0 (±51). Four identical +45° measurements → mean_out = diff_out ±1.
- go pulsed again at g+5 and g+39 during a measurement → ignored; exactly one diff_valid; busy falls at g+40.
- Reset asserted at g+25 for 1 cycle, then a new measurement → no strobe from the aborted run; the counter restarts, so mean_valid comes after 4 further measurements.
